// File: rtl/crossbar_router.sv
// crossbar_router: single-master, N-slave TileLink-UL router with local denial of unmapped, stalled or dead-slave requests
module crossbar_router #(
    parameter int NSLAVES = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [63:0]           a_address,
    input  logic [63:0]           a_data,
    input  logic [7:0]            a_mask,
    output logic [63:0]           pma_address,
    input  logic [5:0]            chip_sel,
    input  logic [63:0]           chip_addr,
    output logic [NSLAVES-1:0]    s_a_valid,
    input  logic [NSLAVES-1:0]    s_a_ready,
    output logic [2:0]            s_a_opcode,
    output logic [63:0]           s_a_address,
    output logic [63:0]           s_a_data,
    output logic [7:0]            s_a_mask,
    input  logic [NSLAVES-1:0]    s_d_valid,
    output logic [NSLAVES-1:0]    s_d_ready,
    input  logic [NSLAVES*64-1:0] s_d_data,
    input  logic [NSLAVES-1:0]    s_d_denied,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [63:0]           d_data,
    output logic                  d_denied
);
    localparam int SW = NSLAVES > 1 ? $clog2(NSLAVES) : 1;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0] NS = 6'(NSLAVES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;
    assign a_ready = state == IDLE;
    assign pma_address = a_address;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= '0;
            cnt <= '0;
            s_a_valid <= '0;
            s_d_ready <= '0;
            s_a_opcode <= '0;
            s_a_address <= '0;
            s_a_data <= '0;
            s_a_mask <= '0;
            d_valid <= 1'b0;
            d_opcode <= '0;
            d_data <= '0;
            d_denied <= 1'b0;
        end else begin
            case (state)
                IDLE: if (a_valid) begin
                    s_a_opcode <= a_opcode;
                    s_a_address <= chip_addr;
                    s_a_data <= a_data;
                    s_a_mask <= a_mask;
                    cnt <= '0;
                    d_opcode <= {2'b00, a_opcode == 3'd4};
                    if (chip_sel == 6'd0 || chip_sel >= NS) begin
                        d_valid <= 1'b1;
                        d_denied <= 1'b1;
                        d_data <= '0;
                        state <= DONE;
                    end else begin
                        sel <= chip_sel[SW-1:0];
                        s_a_valid <= NSLAVES'(1) << chip_sel[SW-1:0];
                        state <= REQ;
                    end
                end
                // a ready slave wins over a timeout expiring in the same cycle
                REQ: if (s_a_ready[sel]) begin
                    s_a_valid <= '0;
                    s_d_ready <= NSLAVES'(1) << sel;
                    state <= RESP;
                end else if (TIMEOUT != 0 && cnt == LAST) begin
                    s_a_valid <= '0;
                    d_valid <= 1'b1;
                    d_denied <= 1'b1;
                    d_data <= '0;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (s_d_valid[sel]) begin
                    s_d_ready <= '0;
                    d_data <= s_d_data[{sel, 6'd0} +: 64];
                    d_denied <= s_d_denied[sel];
                    d_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (d_ready) begin
                    d_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crossbar_router.sv
// tb_crossbar_router: directed vector table plus hand sequences for stalls, timeout, reset and stray responses
module tb_crossbar_router;
    localparam int NS = 5;
    logic clk = 0, rst_n = 0;
    logic a_valid = 0, a_ready;
    logic [2:0] a_opcode = 0;
    logic [63:0] a_address = 0, a_data = 0;
    logic [7:0] a_mask = 0;
    logic [63:0] pma_address, chip_addr;
    logic [5:0] chip_sel;
    logic [NS-1:0] s_a_valid, s_a_ready = 0, s_d_valid = 0, s_d_ready, s_d_denied = 0;
    logic [2:0] s_a_opcode, d_opcode;
    logic [63:0] s_a_address, s_a_data, d_data;
    logic [7:0] s_a_mask;
    logic [NS*64-1:0] s_d_data = 0;
    logic d_valid, d_ready = 0, d_denied;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    crossbar_router #(.NSLAVES(NS), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_address(a_address), .a_data(a_data), .a_mask(a_mask), .pma_address(pma_address),
        .chip_sel(chip_sel), .chip_addr(chip_addr), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_opcode(s_a_opcode), .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_data(s_d_data), .s_d_denied(s_d_denied),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_data(d_data), .d_denied(d_denied)
    );

    // PMA stub: 0x1->RAM2, 0x2->ROM1, 0x3->3, 0x5->5 (out of range), 0x8->RAM4, 0xF->63, else zero page
    always_comb begin
        case (pma_address[31:28])
            4'h1: chip_sel = 6'd2;
            4'h2: chip_sel = 6'd1;
            4'h3: chip_sel = 6'd3;
            4'h5: chip_sel = 6'd5;
            4'h8: chip_sel = 6'd4;
            4'hF: chip_sel = 6'd63;
            default: chip_sel = 6'd0;
        endcase
        chip_addr = {36'd0, pma_address[27:0]};
    end

    typedef struct {
        logic [2:0] op; logic [63:0] addr; logic [63:0] wdata; logic [7:0] mask;
        int sel; logic [63:0] rdata; logic sden;
        logic [4:0] sav; logic [63:0] caddr; int cyc; logic [2:0] dop; logic [63:0] ddata; logic dden;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // unselected slaves return a poison pattern and deny, so a wrong pick is visible
    task automatic set_slaves(input int sel, input logic [63:0] rdata, input logic den);
        for (int k = 0; k < NS; k++) s_d_data[64*k +: 64] = 64'hBAD0_0000_0000_0000 | 64'(k);
        s_d_denied = '1;
        if (sel > 0 && sel < NS) begin
            s_d_data[64*sel +: 64] = rdata;
            s_d_denied[sel] = den;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] m);
        a_valid = 1; a_opcode = op; a_address = addr; a_data = wd; a_mask = m;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0; a_address = 0; a_data = 0; a_mask = 0; a_opcode = 0;
    endtask

    task automatic finish_resp(input string tag);
        d_ready = 1;
        @(negedge clk);
        d_ready = 0;
        chk({tag, " d_valid drop"}, 64'(d_valid), 64'd0);
        chk({tag, " a_ready back"}, 64'(a_ready), 64'd1);
    endtask

    task automatic run(input vec_t v, input string tag);
        int n;
        logic [4:0] sav;
        logic [63:0] ca, cd;
        logic [7:0] cm;
        logic [2:0] co;
        @(negedge clk);
        set_slaves(v.sel, v.rdata, v.sden);
        s_a_ready = '1; s_d_valid = '1;
        chk({tag, " a_ready idle"}, 64'(a_ready), 64'd1);
        a_address = v.addr;
        #1 chk({tag, " pma_address"}, pma_address, v.addr);
        @(negedge clk);
        issue(v.op, v.addr, v.wdata, v.mask);
        sav = 0; n = 1; ca = 0; cd = 0; cm = 0; co = 0;
        while (!d_valid && n < 20) begin
            if (s_a_valid != 0 && sav == 0) begin
                ca = s_a_address; cd = s_a_data; cm = s_a_mask; co = s_a_opcode;
            end
            sav |= s_a_valid;
            @(negedge clk);
            n++;
        end
        sav |= s_a_valid;
        chk({tag, " d_valid"}, 64'(d_valid), 64'd1);
        chk({tag, " latency"}, 64'(n), 64'(v.cyc));
        chk({tag, " s_a_valid"}, 64'(sav), 64'(v.sav));
        if (v.sav != 0) begin
            chk({tag, " s_a_address"}, ca, v.caddr);
            chk({tag, " s_a_data"}, cd, v.wdata);
            chk({tag, " s_a_mask"}, 64'(cm), 64'(v.mask));
            chk({tag, " s_a_opcode"}, 64'(co), 64'(v.op));
        end
        chk({tag, " d_opcode"}, 64'(d_opcode), 64'(v.dop));
        chk({tag, " d_data"}, d_data, v.ddata);
        chk({tag, " d_denied"}, 64'(d_denied), 64'(v.dden));
        finish_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{3'd4, 64'h8000_0010, 64'd0, 8'h00, 4, 64'hDEAD_BEEF, 1'b0, 5'b10000, 64'h10, 3, 3'd1, 64'hDEAD_BEEF, 1'b0};
        vecs[1] = '{3'd0, 64'h1000_0040, 64'h41, 8'h01, 2, 64'h5555, 1'b0, 5'b00100, 64'h40, 3, 3'd0, 64'h5555, 1'b0};
        vecs[2] = '{3'd4, 64'h0000_0800, 64'd0, 8'h00, 0, 64'd0, 1'b0, 5'b00000, 64'd0, 1, 3'd1, 64'd0, 1'b1};
        vecs[3] = '{3'd1, 64'h3000_0008, 64'hA5A5_5A5A_0F0F_F0F0, 8'hF0, 3, 64'h1234, 1'b1, 5'b01000, 64'h8, 3, 3'd0, 64'h1234, 1'b1};
        vecs[4] = '{3'd4, 64'h2000_0100, 64'd0, 8'hFF, 1, 64'hCAFE_F00D_1234_5678, 1'b0, 5'b00010, 64'h100, 3, 3'd1, 64'hCAFE_F00D_1234_5678, 1'b0};
        vecs[5] = '{3'd2, 64'h8000_0020, 64'h77, 8'h0F, 4, 64'h99, 1'b1, 5'b10000, 64'h20, 3, 3'd0, 64'h99, 1'b1};
        vecs[6] = '{3'd0, 64'h5000_0000, 64'h1, 8'h01, 5, 64'd0, 1'b0, 5'b00000, 64'd0, 1, 3'd0, 64'd0, 1'b1};
        vecs[7] = '{3'd4, 64'hF000_0000, 64'd0, 8'h00, 63, 64'd0, 1'b0, 5'b00000, 64'd0, 1, 3'd1, 64'd0, 1'b1};
        vecs[8] = '{3'd4, 64'h1000_0008, 64'd0, 8'hFF, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'b00100, 64'h8, 3, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("rst a_ready", 64'(a_ready), 64'd1);
        chk("rst d_valid", 64'(d_valid), 64'd0);
        chk("rst s_a_valid", 64'(s_a_valid), 64'd0);
        chk("rst s_d_ready", 64'(s_d_ready), 64'd0);
        chk("rst d_denied", 64'(d_denied), 64'd0);
        chk("rst d_data", d_data, 64'd0);
        chk("rst d_opcode", 64'(d_opcode), 64'd0);
        chk("rst s_a_address", s_a_address, 64'd0);
        rst_n = 1;

        for (int i = 0; i < 9; i++) run(vecs[i], $sformatf("vec%0d", i));

        // PutFull with s_a_ready held off 3 cycles and d_ready held off 2 cycles
        @(negedge clk);
        set_slaves(2, 64'h0, 1'b0);
        s_a_ready = '0; s_d_valid = '1;
        issue(3'd0, 64'h1000_0000, 64'h41, 8'h01);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("stall c%0d s_a_valid", c), 64'(s_a_valid), 64'b00100);
            chk($sformatf("stall c%0d payload", c), {s_a_address[31:0], s_a_data[15:0], s_a_mask, 5'd0, s_a_opcode},
                {32'h0, 16'h41, 8'h01, 5'd0, 3'd0});
            if (c == 4) s_a_ready = 5'b00100;
            @(negedge clk);
        end
        s_a_ready = '0;
        chk("stall resp s_d_ready", 64'(s_d_ready), 64'b00100);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d d_valid", c), 64'(d_valid), 64'd1);
            chk($sformatf("hold%0d d_resp", c), {d_data[60:0], d_denied, d_opcode[1:0]}, 64'd0);
            if (c < 2) @(negedge clk);
        end
        finish_resp("stall");

        // timeout: slave 3 never ready
        @(negedge clk);
        set_slaves(3, 64'h3333, 1'b0);
        s_a_ready = '0; s_d_valid = '1;
        issue(3'd4, 64'h3000_0000, 64'd0, 8'hFF);
        n = 0;
        for (int c = 0; c < 30 && !d_valid; c++) begin
            if (s_a_valid == 5'b01000) n++;
            @(negedge clk);
        end
        chk("timeout d_valid", 64'(d_valid), 64'd1);
        chk("timeout s_a_valid cycles", 64'(n), 64'd8);
        chk("timeout d_denied", 64'(d_denied), 64'd1);
        chk("timeout d_data", d_data, 64'd0);
        chk("timeout d_opcode", 64'(d_opcode), 64'd1);
        finish_resp("timeout");

        // ready arrives in the last allowed cycle
        @(negedge clk);
        issue(3'd4, 64'h3000_0000, 64'd0, 8'hFF);
        n = 0;
        for (int c = 0; c < 30 && !d_valid; c++) begin
            if (s_a_valid == 5'b01000) n++;
            if (n == 8) s_a_ready = 5'b01000;
            @(negedge clk);
        end
        s_a_ready = '0;
        chk("late ready s_a_valid cycles", 64'(n), 64'd8);
        chk("late ready d_denied", 64'(d_denied), 64'd0);
        chk("late ready d_data", d_data, 64'h3333);
        finish_resp("late ready");

        // reset while waiting in RESP
        @(negedge clk);
        set_slaves(4, 64'h5757_5757, 1'b0);
        s_a_ready = '1; s_d_valid = '0;
        issue(3'd4, 64'h8000_0010, 64'd0, 8'hFF);
        for (int c = 0; c < 10 && s_d_ready == 0; c++) @(negedge clk);
        chk("pre-reset s_d_ready", 64'(s_d_ready), 64'b10000);
        #2 rst_n = 0;
        #1;
        chk("async rst s_d_ready", 64'(s_d_ready), 64'd0);
        chk("async rst s_a_valid", 64'(s_a_valid), 64'd0);
        chk("async rst d_valid", 64'(d_valid), 64'd0);
        chk("async rst a_ready", 64'(a_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        run(vecs[4], "post-reset rom");

        // stray response from unselected slave 2 while slave 4 is busy
        @(negedge clk);
        set_slaves(4, 64'h0123_4567_89AB_CDEF, 1'b0);
        s_d_denied[2] = 1'b1;
        s_a_ready = '1; s_d_valid = 5'b00100;
        issue(3'd4, 64'h8000_0010, 64'd0, 8'hFF);
        @(negedge clk);
        chk("stray s_d_ready", 64'(s_d_ready), 64'b10000);
        @(negedge clk);
        chk("stray ignored c3", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("stray ignored c4", 64'(d_valid), 64'd0);
        s_d_valid = 5'b10100;
        @(negedge clk);
        chk("stray d_valid", 64'(d_valid), 64'd1);
        chk("stray d_data", d_data, 64'h0123_4567_89AB_CDEF);
        chk("stray d_denied", 64'(d_denied), 64'd0);
        finish_resp("stray");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
